// File: rtl/hpb_wr_initiator_pkg.sv
// ============================================================================
// Package : hpb_pkg
// Purpose : Shared types and width constants for the HPB per-symbol
//           parameter write path (host initiator <-> RAM control block).
// Contents: HPB_ADDR_W / HPB_DATA_W default widths, WR_EN_W byte-enable
//           width, hpb_cmd_t command record, hpb_init_state_t FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package hpb_pkg;

  localparam int HPB_ADDR_W = 14;
  localparam int HPB_DATA_W = 64;
  localparam int WR_EN_W    = 8;

  typedef struct packed {
    logic [HPB_ADDR_W-1:0] addr;
    logic [HPB_DATA_W-1:0] data;
    logic [WR_EN_W-1:0]    byte_en;
  } hpb_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } hpb_init_state_t;

endpackage : hpb_pkg

`default_nettype wire

// File: rtl/hpb_wr_initiator_if.sv
// ============================================================================
// Interface : hpb_if
// Purpose   : Write request bus between the HPB initiator and the strategy
//             RAM control block.
// Signals   : hpb_wr_req      request, held until completion
//             hpb_wr_addr     request address
//             hpb_wr_data     request data
//             hpb_wr_byte_en  request byte enables
//             rcb_wr_done     one-cycle completion pulse from responder
// Modports  : master (initiator side), slave (RAM control block side)
// Revision  : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface hpb_if
  import hpb_pkg::*;
#(
  parameter int ADDR_W = HPB_ADDR_W,
  parameter int DATA_W = HPB_DATA_W
);

  logic                  hpb_wr_req;
  logic [ADDR_W-1:0]     hpb_wr_addr;
  logic [DATA_W-1:0]     hpb_wr_data;
  logic [DATA_W/8-1:0]   hpb_wr_byte_en;
  logic                  rcb_wr_done;

  modport master (
    output hpb_wr_req,
    output hpb_wr_addr,
    output hpb_wr_data,
    output hpb_wr_byte_en,
    input  rcb_wr_done
  );

  modport slave (
    input  hpb_wr_req,
    input  hpb_wr_addr,
    input  hpb_wr_data,
    input  hpb_wr_byte_en,
    output rcb_wr_done
  );

endinterface : hpb_if

`default_nettype wire

// File: rtl/hpb_wr_initiator_cmd_fifo.sv
// ============================================================================
// Module  : hpb_cmd_fifo
// Purpose : Small synchronous FIFO of hpb_cmd_t write commands.
// Ports   : clk, reset_n (async active-low)
//           push, push_cmd   write side (ignored when full)
//           pop              read side (ignored when empty)
//           head             oldest entry, valid while !empty
//           empty            registered occupancy == 0
//           full_nxt         occupancy == DEPTH after this edge
//           empty_nxt        occupancy == 0 after this edge
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hpb_cmd_fifo
  import hpb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  input  wire logic     push,
  input  wire hpb_cmd_t push_cmd,
  input  wire logic     pop,
  output hpb_cmd_t      head,
  output logic          empty,
  output logic          full_nxt,
  output logic          empty_nxt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  hpb_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - CNT_ONE;
    end
  end

  assign full_nxt  = (count_nxt == FULL_CNT);
  assign empty_nxt = (count_nxt == '0);

  // Pointer arithmetic relies on DEPTH being a power of two so the natural
  // wrap of PTR_W bits equals wrap mod DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_cmd;
  end

endmodule : hpb_cmd_fifo

`default_nettype wire

// File: rtl/hpb_wr_initiator.sv
// ============================================================================
// Module  : hpb_wr_initiator
// Purpose : Host-side initiator for the HPB per-symbol parameter write
//           interface. Buffers host write commands and issues them one at a
//           time to the RAM control block, holding each request until the
//           completion pulse (or a timeout) and then inserting one idle cycle.
// Ports   : clk, reset_n                 clock, async active-low reset
//           cfg_valid/ready/addr/data/byte_en   host command port
//           hpb (hpb_if.master)          request bus to RAM control block
//           err_clr                      clears sticky error flags
//           busy                         work pending or in flight
//           wr_done_cnt                  completed writes (wraps)
//           err_timeout                  sticky: request aborted on timeout
//           err_unexp_done               sticky: completion seen while idle
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hpb_wr_initiator
  import hpb_pkg::*;
#(
  parameter int HPB_ADDR_WIDTH = HPB_ADDR_W,
  parameter int HPB_DATA_WIDTH = HPB_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  wire logic                        clk,
  input  wire logic                        reset_n,
  input  wire logic                        cfg_valid,
  output logic                             cfg_ready,
  input  wire logic [HPB_ADDR_WIDTH-1:0]   cfg_addr,
  input  wire logic [HPB_DATA_WIDTH-1:0]   cfg_data,
  input  wire logic [HPB_DATA_WIDTH/8-1:0] cfg_byte_en,
  hpb_if.master                            hpb,
  input  wire logic                        err_clr,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             wr_done_cnt,
  output logic                             err_timeout,
  output logic                             err_unexp_done
);

  localparam int               TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  hpb_init_state_t state;
  hpb_init_state_t state_nxt;

  hpb_cmd_t  push_cmd;
  hpb_cmd_t  head;
  logic      push;
  logic      pop;
  logic      load;
  logic      done_inc;
  logic      abort;
  logic      unexp;
  logic      fifo_empty;
  logic      fifo_full_nxt;
  logic      fifo_empty_nxt;

  logic [TO_W-1:0]             to_cnt;
  logic                        wr_req_q;
  logic [HPB_ADDR_WIDTH-1:0]   wr_addr_q;
  logic [HPB_DATA_WIDTH-1:0]   wr_data_q;
  logic [HPB_DATA_WIDTH/8-1:0] wr_be_q;

  // cfg_ready is registered from the post-edge FIFO occupancy, so it is
  // exact every cycle and a push can never be offered to a full FIFO.
  assign push             = cfg_valid && cfg_ready;
  assign push_cmd.addr    = cfg_addr;
  assign push_cmd.data    = cfg_data;
  assign push_cmd.byte_en = cfg_byte_en;

  hpb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_cmd  (push_cmd),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full_nxt  (fifo_full_nxt),
    .empty_nxt (fifo_empty_nxt)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    done_inc  = 1'b0;
    abort     = 1'b0;
    unexp     = 1'b0;
    case (state)
      IDLE: begin
        if (hpb.rcb_wr_done) unexp = 1'b1;
        if (!fifo_empty) begin
          state_nxt = REQ;
          load      = 1'b1;
        end
      end
      REQ: begin
        if (hpb.rcb_wr_done) begin
          pop       = 1'b1;
          done_inc  = 1'b1;
          state_nxt = GAP;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          // Aborted entry is discarded; a late completion may still arrive
          // in GAP and is counted there.
          pop       = 1'b1;
          abort     = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        // The responder only re-arms after seeing req low, so GAP always
        // lasts exactly one cycle.
        if (hpb.rcb_wr_done) done_inc = 1'b1;
        if (!fifo_empty) begin
          state_nxt = REQ;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      to_cnt         <= '0;
      wr_req_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_be_q        <= '0;
      cfg_ready      <= 1'b0;
      busy           <= 1'b0;
      wr_done_cnt    <= '0;
      err_timeout    <= 1'b0;
      err_unexp_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_req_q  <= (state_nxt == REQ);
      cfg_ready <= !fifo_full_nxt;
      busy      <= (state_nxt != IDLE) || !fifo_empty_nxt;

      if (load) begin
        wr_addr_q <= head.addr;
        wr_data_q <= head.data;
        wr_be_q   <= head.byte_en;
        to_cnt    <= '0;
      end else if (state == REQ) begin
        to_cnt    <= to_cnt + TO_ONE;
      end

      if (done_inc) wr_done_cnt <= wr_done_cnt + CNT_ONE;

      // Set has priority over clear.
      if (abort)        err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;

      if (unexp)        err_unexp_done <= 1'b1;
      else if (err_clr) err_unexp_done <= 1'b0;
    end
  end

  assign hpb.hpb_wr_req     = wr_req_q;
  assign hpb.hpb_wr_addr    = wr_addr_q;
  assign hpb.hpb_wr_data    = wr_data_q;
  assign hpb.hpb_wr_byte_en = wr_be_q;

endmodule : hpb_wr_initiator

`default_nettype wire

// File: tb/tb_hpb_wr_initiator.sv
// ============================================================================
// Module  : tb_hpb_wr_initiator
// Purpose : Self-checking bench for hpb_wr_initiator. dut0 has the timeout
//           disabled (single, back-to-back, stall, backpressure, reset);
//           dut1 uses a 16-cycle timeout (abort, late done, error flags).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hpb_wr_initiator;

  typedef struct {
    logic        valid;
    logic [13:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        done;
    logic        req;
    logic [13:0] eaddr;
    logic [63:0] edata;
    logic [7:0]  ebe;
    logic        ready;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  logic clk;
  logic rst0_n, rst1_n;

  logic        cfg0_valid, cfg0_ready, err0_clr, busy0, err0_to, err0_ud;
  logic [13:0] cfg0_addr;
  logic [63:0] cfg0_data;
  logic [7:0]  cfg0_be;
  logic [15:0] cnt0;

  logic        cfg1_valid, cfg1_ready, err1_clr, busy1, err1_to, err1_ud;
  logic [13:0] cfg1_addr;
  logic [63:0] cfg1_data;
  logic [7:0]  cfg1_be;
  logic [15:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  hpb_if if0 ();
  hpb_if if1 ();

  hpb_wr_initiator #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(rst0_n),
    .cfg_valid(cfg0_valid), .cfg_ready(cfg0_ready), .cfg_addr(cfg0_addr),
    .cfg_data(cfg0_data), .cfg_byte_en(cfg0_be), .hpb(if0),
    .err_clr(err0_clr), .busy(busy0), .wr_done_cnt(cnt0),
    .err_timeout(err0_to), .err_unexp_done(err0_ud)
  );

  hpb_wr_initiator #(.TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .reset_n(rst1_n),
    .cfg_valid(cfg1_valid), .cfg_ready(cfg1_ready), .cfg_addr(cfg1_addr),
    .cfg_data(cfg1_data), .cfg_byte_en(cfg1_be), .hpb(if1),
    .err_clr(err1_clr), .busy(busy1), .wr_done_cnt(cnt1),
    .err_timeout(err1_to), .err_unexp_done(err1_ud)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [13:0] a, input logic [63:0] d,
                              input logic [7:0] b, input logic dn, input logic rq,
                              input logic [13:0] ea, input logic [63:0] ed, input logic [7:0] eb,
                              input logic rdy, input logic bsy, input logic [15:0] c);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.be = b; t.done = dn;
    t.req = rq; t.eaddr = ea; t.edata = ed; t.ebe = eb;
    t.ready = rdy; t.busy = bsy; t.cnt = c;
    return t;
  endfunction

  task automatic drive0(input vec_t t);
    cfg0_valid      = t.valid;
    cfg0_addr       = t.addr;
    cfg0_data       = t.data;
    cfg0_be         = t.be;
    if0.rcb_wr_done = t.done;
  endtask

  localparam logic [63:0] D0 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] DA1 = 64'hA1A1A1A1_A1A1A1A1;
  localparam logic [63:0] DA2 = 64'hA2A2A2A2_A2A2A2A2;
  localparam logic [63:0] DA3 = 64'hA3A3A3A3_A3A3A3A3;

  vec_t tv [17];

  initial begin : main
    int acc, hi, k;
    logic rdy_s;

    // Single write (0..5) then three back-to-back pushes (6..16).
    tv[0]  = mk(0, 14'h000, 64'h0, 8'h00, 0, 0, 14'h000, 64'h0, 8'h00, 1, 0, 16'd0);
    tv[1]  = mk(1, 14'h123, D0,    8'hFF, 0, 0, 14'h000, 64'h0, 8'h00, 1, 1, 16'd0);
    tv[2]  = mk(0, 14'h000, 64'h0, 8'h00, 0, 1, 14'h123, D0,    8'hFF, 1, 1, 16'd0);
    tv[3]  = mk(0, 14'h000, 64'h0, 8'h00, 0, 1, 14'h123, D0,    8'hFF, 1, 1, 16'd0);
    tv[4]  = mk(0, 14'h000, 64'h0, 8'h00, 1, 0, 14'h000, 64'h0, 8'h00, 1, 1, 16'd1);
    tv[5]  = mk(0, 14'h000, 64'h0, 8'h00, 0, 0, 14'h000, 64'h0, 8'h00, 1, 0, 16'd1);
    tv[6]  = mk(1, 14'h0A1, DA1,   8'h01, 0, 0, 14'h000, 64'h0, 8'h00, 1, 1, 16'd1);
    tv[7]  = mk(1, 14'h0A2, DA2,   8'h03, 0, 1, 14'h0A1, DA1,   8'h01, 1, 1, 16'd1);
    tv[8]  = mk(1, 14'h0A3, DA3,   8'h07, 0, 1, 14'h0A1, DA1,   8'h01, 1, 1, 16'd1);
    tv[9]  = mk(0, 14'h000, 64'h0, 8'h00, 1, 0, 14'h000, 64'h0, 8'h00, 1, 1, 16'd2);
    tv[10] = mk(0, 14'h000, 64'h0, 8'h00, 0, 1, 14'h0A2, DA2,   8'h03, 1, 1, 16'd2);
    tv[11] = mk(0, 14'h000, 64'h0, 8'h00, 0, 1, 14'h0A2, DA2,   8'h03, 1, 1, 16'd2);
    tv[12] = mk(0, 14'h000, 64'h0, 8'h00, 1, 0, 14'h000, 64'h0, 8'h00, 1, 1, 16'd3);
    tv[13] = mk(0, 14'h000, 64'h0, 8'h00, 0, 1, 14'h0A3, DA3,   8'h07, 1, 1, 16'd3);
    tv[14] = mk(0, 14'h000, 64'h0, 8'h00, 0, 1, 14'h0A3, DA3,   8'h07, 1, 1, 16'd3);
    tv[15] = mk(0, 14'h000, 64'h0, 8'h00, 1, 0, 14'h000, 64'h0, 8'h00, 1, 1, 16'd4);
    tv[16] = mk(0, 14'h000, 64'h0, 8'h00, 0, 0, 14'h000, 64'h0, 8'h00, 1, 0, 16'd4);

    rst0_n = 1'b0; rst1_n = 1'b0;
    drive0(tv[0]);
    err0_clr = 1'b0;
    cfg1_valid = 1'b0; cfg1_addr = '0; cfg1_data = '0; cfg1_be = '0;
    err1_clr = 1'b0; if1.rcb_wr_done = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req",   {127'b0, if0.hpb_wr_req}, 128'd0);
    chk("rst_ready", {127'b0, cfg0_ready}, 128'd0);
    chk("rst_busy",  {127'b0, busy0}, 128'd0);
    chk("rst_cnt",   {112'b0, cnt0}, 128'd0);
    chk("rst_errs",  {126'b0, err0_to, err0_ud}, 128'd0);
    rst0_n = 1'b1; rst1_n = 1'b1;

    // ---------------- table-driven vectors on dut0 ----------------
    for (int i = 0; i < 17; i++) begin
      drive0(tv[i]);
      @(negedge clk);
      chk($sformatf("v%0d_req", i),   {127'b0, if0.hpb_wr_req}, {127'b0, tv[i].req});
      if (tv[i].req) begin
        chk($sformatf("v%0d_cmd", i),
            {42'b0, if0.hpb_wr_addr, if0.hpb_wr_data, if0.hpb_wr_byte_en},
            {42'b0, tv[i].eaddr, tv[i].edata, tv[i].ebe});
      end
      chk($sformatf("v%0d_ready", i), {127'b0, cfg0_ready}, {127'b0, tv[i].ready});
      chk($sformatf("v%0d_busy", i),  {127'b0, busy0}, {127'b0, tv[i].busy});
      chk($sformatf("v%0d_cnt", i),   {112'b0, cnt0}, {112'b0, tv[i].cnt});
      chk($sformatf("v%0d_errs", i),  {126'b0, err0_to, err0_ud}, 128'd0);
    end

    // ---------------- stall: done withheld 50 cycles ----------------
    cfg0_valid = 1'b1; cfg0_addr = 14'h1555; cfg0_data = 64'h01234567_89ABCDEF; cfg0_be = 8'h5A;
    @(negedge clk);
    cfg0_valid = 1'b0;
    k = 0;
    while (!if0.hpb_wr_req && k < 10) begin @(negedge clk); k++; end
    chk("stall_req_seen", {127'b0, if0.hpb_wr_req}, 128'd1);
    for (int c = 0; c < 50; c++) begin
      chk("stall_hold", {41'b0, if0.hpb_wr_req, if0.hpb_wr_addr, if0.hpb_wr_data, if0.hpb_wr_byte_en},
          {41'b0, 1'b1, 14'h1555, 64'h01234567_89ABCDEF, 8'h5A});
      @(negedge clk);
    end
    if0.rcb_wr_done = 1'b1;
    @(negedge clk);
    if0.rcb_wr_done = 1'b0;
    chk("stall_req_low", {127'b0, if0.hpb_wr_req}, 128'd0);
    chk("stall_cnt", {112'b0, cnt0}, 128'd5);
    chk("stall_no_to", {127'b0, err0_to}, 128'd0);
    @(negedge clk);
    chk("stall_idle_busy", {127'b0, busy0}, 128'd0);

    // ---------------- backpressure: responder silent ----------------
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      cfg0_valid = 1'b1; cfg0_addr = 14'h200 + 14'(acc);
      cfg0_data = 64'hB0B0_0000_0000_0000 + 64'(acc); cfg0_be = 8'hF0;
      rdy_s = cfg0_ready;
      @(negedge clk);
      if (rdy_s) acc++;
    end
    chk("bp_accepted", 128'(acc), 128'd4);
    chk("bp_ready_low", {127'b0, cfg0_ready}, 128'd0);
    chk("bp_req_addr", {113'b0, if0.hpb_wr_req, if0.hpb_wr_addr}, {113'b0, 1'b1, 14'h200});
    cfg0_addr = 14'h2FF;
    repeat (3) @(negedge clk);
    chk("bp_ready_held", {127'b0, cfg0_ready}, 128'd0);
    if0.rcb_wr_done = 1'b1;
    @(negedge clk);
    if0.rcb_wr_done = 1'b0; cfg0_valid = 1'b0;
    chk("bp_ready_back", {127'b0, cfg0_ready}, 128'd1);
    chk("bp_gap_req", {127'b0, if0.hpb_wr_req}, 128'd0);
    chk("bp_cnt", {112'b0, cnt0}, 128'd6);
    @(negedge clk);
    chk("bp_next_addr", {113'b0, if0.hpb_wr_req, if0.hpb_wr_addr}, {113'b0, 1'b1, 14'h201});
    if0.rcb_wr_done = 1'b1;
    @(negedge clk);
    if0.rcb_wr_done = 1'b0;
    @(negedge clk);
    chk("bp_third_addr", {113'b0, if0.hpb_wr_req, if0.hpb_wr_addr}, {113'b0, 1'b1, 14'h202});

    // ---------------- async reset mid-REQ, two entries buffered ----------------
    #2;
    rst0_n = 1'b0;
    #1;
    chk("arst_req", {127'b0, if0.hpb_wr_req}, 128'd0);
    chk("arst_busy_cnt", {111'b0, busy0, cnt0}, 128'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_busy", {127'b0, busy0}, 128'd0);
    chk("arst_rel_ready", {127'b0, cfg0_ready}, 128'd1);
    repeat (2) @(negedge clk);
    chk("arst_no_reissue", {126'b0, if0.hpb_wr_req, busy0}, 128'd0);

    // ---------------- timeout and error flags on dut1 ----------------
    cfg1_valid = 1'b1; cfg1_addr = 14'h300; cfg1_data = 64'h3; cfg1_be = 8'h01;
    @(negedge clk);
    cfg1_addr = 14'h301; cfg1_data = 64'h4; cfg1_be = 8'h02;
    @(negedge clk);
    cfg1_valid = 1'b0;
    chk("to_first_req", {113'b0, if1.hpb_wr_req, if1.hpb_wr_addr}, {113'b0, 1'b1, 14'h300});
    chk("to_flag_pre", {127'b0, err1_to}, 128'd0);
    hi = 1;
    while (if1.hpb_wr_req && hi < 40) begin @(negedge clk); if (if1.hpb_wr_req) hi++; end
    chk("to_req_cycles", 128'(hi), 128'd16);
    chk("to_flag_set", {127'b0, err1_to}, 128'd1);
    chk("to_cnt_zero", {112'b0, cnt1}, 128'd0);
    @(negedge clk);
    chk("to_next_req", {113'b0, if1.hpb_wr_req, if1.hpb_wr_addr}, {113'b0, 1'b1, 14'h301});
    hi = 1;
    while (if1.hpb_wr_req && hi < 40) begin @(negedge clk); if (if1.hpb_wr_req) hi++; end
    chk("to_req_cycles2", 128'(hi), 128'd16);
    // Late completion during GAP: counted, not an error.
    if1.rcb_wr_done = 1'b1;
    @(negedge clk);
    if1.rcb_wr_done = 1'b0;
    chk("late_done_cnt", {112'b0, cnt1}, 128'd1);
    chk("late_done_noerr", {127'b0, err1_ud}, 128'd0);
    chk("late_done_idle", {126'b0, if1.hpb_wr_req, busy1}, 128'd0);
    // Completion while idle.
    if1.rcb_wr_done = 1'b1;
    @(negedge clk);
    if1.rcb_wr_done = 1'b0;
    chk("unexp_set", {126'b0, err1_to, err1_ud}, 128'd3);
    chk("unexp_cnt", {112'b0, cnt1}, 128'd1);
    // Clear with a simultaneous set: set wins for err_unexp_done.
    err1_clr = 1'b1; if1.rcb_wr_done = 1'b1;
    @(negedge clk);
    if1.rcb_wr_done = 1'b0;
    chk("clr_set_wins", {126'b0, err1_to, err1_ud}, 128'd1);
    @(negedge clk);
    err1_clr = 1'b0;
    chk("clr_both", {126'b0, err1_to, err1_ud}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hpb_wr_initiator

`default_nettype wire

// File: doc/hpb_wr_initiator.md
Name: hpb_wr_initiator

Overview:
- Host-side initiator for the HPB per-symbol parameter write interface.
- Accepts host configuration write commands on a valid/ready port and buffers them in a small FIFO.
- Issues one request at a time to the RAM control block: hpb_wr_req with addr/data/byte_en, held until rcb_wr_done, then dropped.
- Sits between host register/config logic and the strategy RAM control block; top level binds its hpb_* / rcb_wr_done ports to hpb_if.

Parameters:
- HPB_ADDR_WIDTH, 14, write address width; matches RAM address width.
- HPB_DATA_WIDTH, 64, write data width; must be a multiple of 8.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- TIMEOUT_CYCLES, 1024, max cycles in REQ before abort; 0 disables timeout.
- CNT_WIDTH, 16, status counter width.

Ports:
- clk  in  1  core clock
- reset_n  in  1  reset; asynchronous assert, active low
- cfg_valid  in  1  host command valid
- cfg_ready  out  1  command accepted when valid&&ready
- cfg_addr  in  HPB_ADDR_WIDTH  command address
- cfg_data  in  HPB_DATA_WIDTH  command data
- cfg_byte_en  in  HPB_DATA_WIDTH/8  command byte enables
- hpb_wr_req  out  1  write request to RAM control block
- hpb_wr_addr  out  HPB_ADDR_WIDTH  request address
- hpb_wr_data  out  HPB_DATA_WIDTH  request data
- hpb_wr_byte_en  out  HPB_DATA_WIDTH/8  request byte enables
- rcb_wr_done  in  1  one-cycle completion pulse from RAM control block
- err_clr  in  1  clears sticky error flags
- busy  out  1  FIFO non-empty or FSM not IDLE
- wr_done_cnt  out  CNT_WIDTH  completed writes, wraps
- err_timeout  out  1  sticky: request aborted on timeout
- err_unexp_done  out  1  sticky: rcb_wr_done seen in IDLE

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FIFO empty, FSM=IDLE, counters 0. Reset mid-request drops hpb_wr_req immediately and discards all buffered commands.
- All outputs are registered. cfg_ready = !fifo_full, registered from FIFO state.
- FIFO: push on cfg_valid&&cfg_ready. Pop only on completion or abort. A push and a pop in the same cycle are both honoured. Count saturates at FIFO_DEPTH; pointers wrap mod FIFO_DEPTH.
- FSM states: IDLE, REQ, GAP.
- IDLE -> REQ when FIFO non-empty:
  - The FIFO head is loaded into hpb_wr_addr/data/byte_en, and hpb_wr_req is set, at the same edge.
  - Timeout counter is cleared.
- REQ:
  - Address, data and byte_en are held stable and hpb_wr_req held high; the responder may stall arbitrarily while feed reads have priority.
  - On rcb_wr_done: hpb_wr_req<=0, pop FIFO, wr_done_cnt++, go to GAP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: hpb_wr_req<=0, pop (discard entry), err_timeout<=1, go to GAP.
- GAP:
  - Exactly one cycle with hpb_wr_req low. This is mandatory: the responder ignores a held request until it observes req low.
  - rcb_wr_done in GAP is a late completion of the aborted entry: wr_done_cnt++, no error.
  - Next state: REQ (head loaded) if FIFO non-empty, else IDLE.
- Timing: responder accepts at cycle N, done at N+1, req low at N+2, next req high at N+3. Peak throughput is 1 write per 3 cycles.
- rcb_wr_done in IDLE sets err_unexp_done; no other effect.
- err_clr clears both sticky flags. If a set event occurs in the same cycle, set wins.
- wr_done_cnt wraps at 2^CNT_WIDTH.
- busy = (state!=IDLE) || fifo_not_empty.

Decomposition:
- Package hpb_pkg:
  - hpb_cmd_t packed struct {addr, data, byte_en} using the width constants.
  - hpb_init_state_t enum {IDLE, REQ, GAP}.
  - WR_EN_W=8.
  - Default HPB_ADDR_WIDTH/HPB_DATA_WIDTH constants shared with the RAM control block.
- One sub-module, hpb_cmd_fifo: synchronous FIFO of hpb_cmd_t with push/pop/full/empty/head, async active-low reset.
- FSM, timeout counter and status registers live in hpb_wr_initiator.

Test Plan:
- Single write: push addr=0x0123, data=0xDEADBEEF_CAFEF00D, be=0xFF; responder model done 1 cycle after req -> req high 1 cycle after push, req low 2 cycles later, wr_done_cnt=1, busy=0 after GAP.
- Back-to-back: push 3 commands on consecutive cycles; responder done=req delayed 1 -> req rising edges exactly 3 cycles apart, addrs in push order, wr_done_cnt=3.
- Stall: responder withholds done for 50 cycles (emulated feed-read priority) -> req, addr, data, byte_en constant for all 50 cycles; single completion, no err_timeout.
- Backpressure: responder never completes, TIMEOUT_CYCLES=0 -> after FIFO_DEPTH (4) accepted pushes cfg_ready=0; further cfg_valid ignored until first done, then cfg_ready=1 the following cycle.
- Timeout and errors: TIMEOUT_CYCLES=16, no done -> req drops after 16 cycles, err_timeout=1, entry discarded, next entry issued after GAP. Then pulse done in IDLE -> err_unexp_done=1; err_clr -> both 0.
- Reset mid-REQ: assert reset_n=0 asynchronously with 2 commands buffered -> hpb_wr_req=0 without waiting for a clock edge; after release, busy=0 and cfg_ready=1.
